hemaia_spi_master: RTL and testbench
====================================

# hemaia_spi_master

Host-side SPI master that issues command/address/data frames to the chip's AXI-over-SPI slave port. It sits in the host FPGA, test harness, or a companion die. It accepts one memory-access request at a time on a valid/ready interface. It serializes the request in single-lane or quad-lane SPI mode 0, captures read data, and returns one response per request. It is the initiator for the SPI slave bridge, which turns these frames into AXI-lite transactions.

## Interface
- `CLK_DIV`, 4: SCLK half-period in `clk_i` cycles; legal range ≥1.
- `DUMMY_CYCLES`, 32: SCLK cycles between the last address bit and the first read-data bit; reads only.
- `ADDR_WIDTH`, 32: address bits sent per frame; must be a multiple of 4.
- `DATA_WIDTH`, 32: data bits per frame; must be a multiple of 4.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when high together with `req_valid_i`.
- `req_write_i` in 1: 1 = write frame, 0 = read frame.
- `req_quad_i` in 1: 1 = address/data on 4 lanes.
- `req_cmd_i` in 8: command byte, e.g. 0x02 = write mem, 0x0B = read mem.
- `req_addr_i` in ADDR_WIDTH: target address.
- `req_wdata_i` in DATA_WIDTH: write data.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumed.
- `rsp_rdata_o` out DATA_WIDTH: read data; 0 for writes.
- `busy_o` out 1: high whenever the state is not IDLE.
- `spi_sclk_o` out 1: SPI clock; idles low.
- `spi_cs_o` out 1: chip select, active-low.
- `spi_oen_o` out 4: per-lane output enable; 0 = drive, 1 = tri-state.
- `spi_sdo_o` out 4: lanes driven to the slave.
- `spi_sdi_i` in 4: lanes from the slave.

## Operation
- Reset values:
  - `spi_cs_o`=1, `spi_sclk_o`=0, `spi_oen_o`=4'hF, `spi_sdo_o`=0.
  - `req_ready_o`=0 during reset, then 1 in IDLE.
  - `rsp_valid_o`=0, `rsp_rdata_o`=0, `busy_o`=0.
- FSM states: IDLE → CS_SETUP → CMD → ADDR → (write: WDATA | read: DUMMY → RDATA) → CS_HOLD → RESP → IDLE.
- IDLE: `req_ready_o`=1.
  - On handshake, register all request fields.
  - Drop ready and enter CS_SETUP.
- CMD: always single-lane, 8 bits, MSB first on `spi_sdo_o[0]`.
  - `spi_oen_o`=4'b1110.
- ADDR/WDATA lane use:
  - Single: 1 bit per SCLK on lane 0, `spi_oen_o`=4'b1110.
  - Quad: 1 nibble per SCLK, nibble bit 3 on lane 3, `spi_oen_o`=4'b0000.
  - MSB first in both modes.
- DUMMY: `DUMMY_CYCLES` SCLK pulses, no data.
  - Quad: `spi_oen_o`=4'hF.
  - Single: `spi_oen_o`=4'b1110, `spi_sdo_o[0]`=0.
- RDATA: sample on SCLK rising edge, MSB first.
  - Single: data on `spi_sdi_i[1]`.
  - Quad: nibble on `spi_sdi_i[3:0]`.
  - Quad: `spi_oen_o`=4'hF.
- RESP: `rsp_valid_o`=1 with `rsp_rdata_o` stable until `rsp_ready_i`; then IDLE. Writes also produce a response.
- Bit counter width: ⌈log2(max(ADDR_WIDTH, DATA_WIDTH, DUMMY_CYCLES, 8))⌉+1.
- A phase ends when the counter hits the phase length; the counter reloads to 0 at each phase boundary.
- Reset mid-frame: all outputs return to reset values immediately. The captured request and partial read data are discarded and no response is issued.

## Timing
- Handshake cycle N: `spi_cs_o` goes low at N+1.
- First SCLK rising edge occurs `CLK_DIV` cycles after CS goes low.
- SCLK toggles every `CLK_DIV` cycles; each SCLK period is 2·`CLK_DIV` clk cycles.
- `spi_sdo_o` changes only on SCLK falling edges or at CS assertion. It is stable ≥`CLK_DIV` cycles before each rising edge.
- Frame length in SCLK periods:
  - Single write: 8+A+D.
  - Quad write: 8+A/4+D/4.
  - Single read: 8+A+DUMMY_CYCLES+D.
  - Quad read: 8+A/4+DUMMY_CYCLES+D/4.
- CS_HOLD: `spi_cs_o` rises `CLK_DIV` cycles after the final falling edge.
- CS then stays high for ≥2·`CLK_DIV` cycles before the next frame; `req_ready_o` stays 0 for this interval.
- `rsp_valid_o` asserts in the cycle CS rises.
- No request is accepted while `rsp_valid_o`=1.

## Configuration
- `HEMAIA_SPI_MASTER_QUAD_EN` defined: quad mode is available per request via `req_quad_i`.
- Not defined:
  - `req_quad_i` is ignored and all frames are single-lane.
  - `spi_oen_o[3:2]` is tied to 2'b11 and `spi_sdo_o[3:1]` is tied to 0.
  - Quad nibble logic is removed.

## Test plan
- Reset: assert `rst_i` mid-ADDR. The next cycle shows `spi_cs_o`=1, `spi_sclk_o`=0, `spi_oen_o`=4'hF, `busy_o`=0. After release, `req_ready_o`=1 and no response appears.
- Single write, `CLK_DIV`=2, cmd 0x02, addr 0x1000_0000, data 0xDEADBEEF. Expect exactly 72 SCLK rising edges. The slave model decodes 0x02/0x10000000/0xDEADBEEF. `rsp_valid_o` asserts with `rsp_rdata_o`=0.
- Quad read, cmd 0x0B, addr 0x0000_0040, `DUMMY_CYCLES`=32. The slave model drives 0xCAFEF00D. Expect 8+8+32+8=56 SCLK periods, `spi_oen_o`=4'hF from the start of DUMMY, and `rsp_rdata_o`=0xCAFEF00D.
- Response back-pressure: hold `rsp_ready_i`=0 for 10 cycles. `rsp_valid_o` and data stay stable and `req_ready_o` stays 0. One cycle after `rsp_ready_i`=1, expect IDLE.
- Back-to-back requests: assert a second `req_valid_i` during a frame. It is not accepted until IDLE. CS high time between frames ≥2·`CLK_DIV` cycles.
- Macro off: issue a request with `req_quad_i`=1. The frame is single-lane (72 SCLK for a write) and `spi_oen_o[3:1]` never drives.

Source files
------------

// File: rtl/hemaia_spi_master.sv
// hemaia_spi_master: SPI mode-0 initiator issuing cmd/addr/data frames to the AXI-over-SPI slave.
// Optional feature macro HEMAIA_SPI_MASTER_QUAD_EN enables per-request quad-lane address/data.
module hemaia_spi_master #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned DUMMY_CYCLES = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic                  req_quad_i,
  input  logic [7:0]            req_cmd_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  busy_o,
  output logic                  spi_sclk_o,
  output logic                  spi_cs_o,
  output logic [3:0]            spi_oen_o,
  output logic [3:0]            spi_sdo_o,
  input  logic [3:0]            spi_sdi_i
);

  localparam int unsigned LEN_AD  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned LEN_ADC = (LEN_AD > DUMMY_CYCLES) ? LEN_AD : DUMMY_CYCLES;
  localparam int unsigned MAX_LEN = (LEN_ADC > 8) ? LEN_ADC : 8;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN) + 1;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV + 1);
  localparam int unsigned GAP_W   = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(2 * CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, CS_SETUP, CMD, ADDR, WDATA, DUMMY, RDATA, CS_HOLD, RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q;
  logic [CNT_W-1:0]        cnt_q, cnt_inc, phase_len;
  logic [GAP_W-1:0]        gap_q;
  logic                    sclk_q, write_q, quad_q;
  logic [7:0]              cmd_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q, rd_next;
  logic                    timed, shifting, tick, rise, fall, last, hs;

  assign shifting = state_q inside {CMD, ADDR, WDATA, DUMMY, RDATA};
  assign timed    = shifting || (state_q == CS_SETUP) || (state_q == CS_HOLD);
  assign tick     = timed && (div_q == DIV_LAST);
  assign rise     = shifting && tick && !sclk_q;
  assign fall     = shifting && tick && sclk_q;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign last     = (cnt_inc == phase_len);

  // Ready also waits out the minimum CS-high gap counted from the end of the previous frame.
  assign req_ready_o = (state_q == IDLE) && (gap_q == GAP_MAX) && !rst_i;
  assign hs          = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign busy_o      = (state_q != IDLE);
  assign spi_sclk_o  = sclk_q;
  assign spi_cs_o    = (state_q == IDLE) || (state_q == RESP);

  always_comb begin
    phase_len = CNT_W'(8);
    case (state_q)
      ADDR:         phase_len = quad_q ? CNT_W'(ADDR_WIDTH / 4) : CNT_W'(ADDR_WIDTH);
      WDATA, RDATA: phase_len = quad_q ? CNT_W'(DATA_WIDTH / 4) : CNT_W'(DATA_WIDTH);
      DUMMY:        phase_len = CNT_W'(DUMMY_CYCLES);
      default:      phase_len = CNT_W'(8);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    spi_oen_o = 4'hF;
    spi_sdo_o = '0;
    case (state_q)
      IDLE:     if (hs) state_d = CS_SETUP;
      CS_SETUP: if (tick) state_d = CMD;
      CMD:      if (fall && last) state_d = ADDR;
      ADDR: begin
        if (fall && last) begin
          if (write_q)               state_d = WDATA;
          else if (DUMMY_CYCLES != 0) state_d = DUMMY;
          else                       state_d = RDATA;
        end
      end
      DUMMY:        if (fall && last) state_d = RDATA;
      WDATA, RDATA: if (fall && last) state_d = CS_HOLD;
      CS_HOLD:      if (tick) state_d = RESP;
      RESP:         if (rsp_ready_i) state_d = IDLE;
      default:      state_d = IDLE;
    endcase

    case (state_q)
      CS_SETUP, CMD: begin spi_oen_o = 4'b1110; spi_sdo_o[0] = cmd_q[7]; end
      ADDR:          begin spi_oen_o = 4'b1110; spi_sdo_o[0] = addr_q[ADDR_WIDTH-1]; end
      WDATA:         begin spi_oen_o = 4'b1110; spi_sdo_o[0] = wdata_q[DATA_WIDTH-1]; end
      DUMMY, RDATA:  spi_oen_o = 4'b1110;
      default:       ;
    endcase
`ifdef HEMAIA_SPI_MASTER_QUAD_EN
    if (quad_q) begin
      case (state_q)
        ADDR:         begin spi_oen_o = 4'b0000; spi_sdo_o = addr_q[ADDR_WIDTH-1 -: 4]; end
        WDATA:        begin spi_oen_o = 4'b0000; spi_sdo_o = wdata_q[DATA_WIDTH-1 -: 4]; end
        DUMMY, RDATA: spi_oen_o = 4'hF;
        default:      ;
      endcase
    end
`endif
  end

`ifdef HEMAIA_SPI_MASTER_QUAD_EN
  logic [DATA_WIDTH+3:0] rd_quad;
  assign rd_quad = {rdata_q, spi_sdi_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)   quad_q <= 1'b0;
    else if (hs) quad_q <= req_quad_i;
  end
`else
  logic [3:0] unused_in;
  assign quad_q    = 1'b0;
  assign unused_in = {req_quad_i, spi_sdi_i[3:2], spi_sdi_i[0]};
`endif

  always_comb begin
    rd_next = {rdata_q[DATA_WIDTH-2:0], spi_sdi_i[1]};
`ifdef HEMAIA_SPI_MASTER_QUAD_EN
    if (quad_q) rd_next = rd_quad[DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= GAP_MAX;
      sclk_q  <= 1'b0;
      write_q <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= (timed && !tick) ? div_q + DIV_W'(1) : '0;

      if (state_q == CS_HOLD)   gap_q <= '0;
      else if (gap_q != GAP_MAX) gap_q <= gap_q + GAP_W'(1);

      if ((state_q == CS_SETUP) && tick) sclk_q <= 1'b1;
      else if (rise)                     sclk_q <= 1'b1;
      else if (fall)                     sclk_q <= 1'b0;

      if (hs) begin
        write_q <= req_write_i;
        cmd_q   <= req_cmd_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        rdata_q <= '0;
        cnt_q   <= '0;
      end

      // Outgoing data advances on the falling edge so lanes are settled a half-period before each rise.
      if (fall) begin
        cnt_q <= last ? '0 : cnt_inc;
        case (state_q)
          CMD:     cmd_q   <= {cmd_q[6:0], 1'b0};
          ADDR:    addr_q  <= quad_q ? (addr_q << 4) : (addr_q << 1);
          WDATA:   wdata_q <= quad_q ? (wdata_q << 4) : (wdata_q << 1);
          default: ;
        endcase
      end

      if (rise && (state_q == RDATA)) rdata_q <= rd_next;
    end
  end

endmodule

// File: tb/tb_hemaia_spi_master.sv
// Directed bench for hemaia_spi_master (CLK_DIV=2) with a mode-0 slave model that decodes and drives lanes.
module tb_hemaia_spi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_quad;
  logic [7:0]  req_cmd;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        rsp_valid, rsp_ready, busy;
  logic        spi_sclk, spi_cs;
  logic [3:0]  spi_oen, spi_sdo, spi_sdi;

  hemaia_spi_master #(
    .CLK_DIV(2), .DUMMY_CYCLES(32), .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_quad_i(req_quad), .req_cmd_i(req_cmd), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .busy_o(busy),
    .spi_sclk_o(spi_sclk), .spi_cs_o(spi_cs), .spi_oen_o(spi_oen), .spi_sdo_o(spi_sdo),
    .spi_sdi_i(spi_sdi)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0, failures = 0;
  int          edges = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, first_rise_cyc = 0, hs_cyc = 0;
  int          min_gap = 1000, hi_lane = 0, rdy_in_rsp = 0, rsp_cycles = 0, hs_count = 0;
  bit          have_rise = 0, rd_quad_mode = 0;
  int          rd_start = 1000;
  logic [31:0] rd_word = '0;
  logic [3:0]  mosi   [0:127];
  logic [3:0]  oen_at [0:127];
  logic [31:0] d;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] decode(input int unsigned s, input int unsigned n, input bit q);
    logic [31:0] v = '0;
    for (int unsigned i = s; i < s + n; i++)
      v = q ? {v[27:0], mosi[i]} : {v[30:0], mosi[i][0]};
    return v;
  endfunction

  // Slave model: observes at negedge clk, drives read data while SCLK is low.
  initial begin
    logic cs_prev = 1'b1, sclk_prev = 1'b0;
    int   k;
    spi_sdi = '0;
    forever begin
      @(negedge clk);
      if (cs_prev && !spi_cs) begin
        edges = 0;
        cs_fall_cyc = cyc;
        if (have_rise && (cyc - cs_rise_cyc) < min_gap) min_gap = cyc - cs_rise_cyc;
      end
      if (!cs_prev && spi_cs) begin
        cs_rise_cyc = cyc;
        have_rise = 1;
      end
      if (!sclk_prev && spi_sclk && !spi_cs) begin
        if (edges == 0) first_rise_cyc = cyc;
        if (edges < 128) begin
          mosi[edges]   = spi_sdo;
          oen_at[edges] = spi_oen;
        end
        edges++;
      end
      if (!spi_cs && spi_oen[3:1] != 3'b111) hi_lane++;
      if (req_ready && rsp_valid) rdy_in_rsp++;
      if (rsp_valid) rsp_cycles++;
      if (req_valid && req_ready) hs_count++;
      if (!spi_sclk) begin
        spi_sdi = '0;
        k = edges - rd_start;
        if (edges >= rd_start && rd_quad_mode && k < 8) spi_sdi = rd_word[31 - 4*k -: 4];
        else if (edges >= rd_start && !rd_quad_mode && k < 32) spi_sdi[1] = rd_word[31 - k];
      end
      cs_prev = spi_cs;
      sclk_prev = spi_sclk;
    end
  end

  task automatic do_req(input logic w, input logic q, input logic [7:0] c,
                        input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_quad = q; req_cmd = c; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    if (!req_ready) check("req_accept_timeout", 0, 1);
    hs_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int bp, output logic [31:0] data);
    int n = 0, bad = 0;
    while (!rsp_valid && n < 5000) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      check("rsp_timeout", 0, 1);
      data = '0;
      return;
    end
    data = rsp_rdata;
    repeat (bp) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== data || req_ready) bad++;
    end
    if (bp > 0) check("rsp_backpressure_stable", bad, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("idle_after_rsp", {busy, rsp_valid}, 2'b00);
  endtask

  initial begin
    int n;
    int rsp_snap, hs_snap;
    rst = 1'b1; req_valid = 0; req_write = 0; req_quad = 0; req_cmd = '0;
    req_addr = '0; req_wdata = '0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_cs", spi_cs, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_oen", spi_oen, 4'hF);
    check("rst_sdo", spi_sdo, 4'h0);
    check("rst_ready_low", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", req_ready, 1);

    // Single-lane write
    rd_start = 1000;
    do_req(1'b1, 1'b0, 8'h02, 32'h1000_0000, 32'hDEAD_BEEF);
    wait_rsp(0, d);
    check("wr_edges", edges, 72);
    check("wr_cmd", decode(0, 8, 0), 32'h02);
    check("wr_addr", decode(8, 32, 0), 32'h1000_0000);
    check("wr_data", decode(40, 32, 0), 32'hDEAD_BEEF);
    check("wr_rdata_zero", d, 0);
    check("cs_after_hs", cs_fall_cyc - hs_cyc, 1);
    check("first_rise_delay", first_rise_cyc - cs_fall_cyc, 2);

    // Single-lane read with response back-pressure
    rd_quad_mode = 0; rd_word = 32'hCAFE_F00D; rd_start = 72;
    do_req(1'b0, 1'b0, 8'h0B, 32'h0000_0040, 32'h0);
    wait_rsp(10, d);
    check("rd_edges", edges, 104);
    check("rd_cmd", decode(0, 8, 0), 32'h0B);
    check("rd_addr", decode(8, 32, 0), 32'h40);
    check("rd_dummy_sdo_zero", decode(40, 32, 0), 0);
    check("rd_data", d, 32'hCAFE_F00D);

`ifdef HEMAIA_SPI_MASTER_QUAD_EN
    hi_lane = 0; rd_quad_mode = 1; rd_word = 32'hCAFE_F00D; rd_start = 48;
    do_req(1'b0, 1'b1, 8'h0B, 32'h0000_0040, 32'h0);
    wait_rsp(0, d);
    check("qrd_edges", edges, 56);
    check("qrd_cmd", decode(0, 8, 0), 32'h0B);
    check("qrd_addr", decode(8, 8, 1), 32'h40);
    check("qrd_addr_oen", oen_at[8], 4'h0);
    check("qrd_dummy_oen", oen_at[16], 4'hF);
    check("qrd_rdata_oen", oen_at[48], 4'hF);
    check("qrd_lanes_driven", hi_lane != 0, 1);
    check("qrd_data", d, 32'hCAFE_F00D);
    rd_quad_mode = 0;
`else
    hi_lane = 0; rd_start = 1000;
    do_req(1'b1, 1'b1, 8'h02, 32'h0000_0040, 32'h1234_5678);
    wait_rsp(0, d);
    check("nq_edges", edges, 72);
    check("nq_hi_lanes_tristate", hi_lane, 0);
    check("nq_addr", decode(8, 32, 0), 32'h40);
    check("nq_data", decode(40, 32, 0), 32'h1234_5678);
`endif

    // Back-to-back: second request held valid during the first frame
    rd_start = 1000; min_gap = 1000;
    hs_snap = hs_count;
    do_req(1'b1, 1'b0, 8'h02, 32'h0000_0020, 32'h1111_1111);
    req_valid = 1'b1; req_write = 1'b1; req_quad = 1'b0; req_cmd = 8'h02;
    req_addr = 32'h0000_0024; req_wdata = 32'h2222_2222;
    wait_rsp(0, d);
    check("b2b_not_accepted_early", hs_count - hs_snap, 1);
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check("b2b_ready_when_idle", {req_ready, busy}, 2'b10);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(0, d);
    check("b2b_second_data", decode(40, 32, 0), 32'h2222_2222);
    check("b2b_cs_gap_ok", min_gap >= 4, 1);
    check("no_ready_during_rsp", rdy_in_rsp, 0);

    // Reset mid-ADDR
    do_req(1'b1, 1'b0, 8'h02, 32'hAAAA_5555, 32'h0F0F_0F0F);
    n = 0;
    while (edges != 12 && n < 500) begin @(negedge clk); n++; end
    check("reached_addr", edges, 12);
    rst = 1'b1;
    #1;
    check("midrst_cs", spi_cs, 1);
    check("midrst_sclk", spi_sclk, 0);
    check("midrst_oen", spi_oen, 4'hF);
    check("midrst_sdo", spi_sdo, 4'h0);
    check("midrst_busy", busy, 0);
    rsp_snap = rsp_cycles;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", req_ready, 1);
    repeat (40) @(negedge clk);
    check("postrst_no_rsp", rsp_cycles - rsp_snap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
